// File: rtl/data_mem_pkg.sv
// Shared definitions for the core's load/store path and the data memory.
// The memory request/response structs match the core's view of the port;
// dmem_state_e is the data memory's handshake state.
package data_mem_pkg;

   // Request from the core's load/store unit.
   // yumi here is the core's acknowledge of a memory response.
   typedef struct packed {
      logic [31:0] write_data;
      logic        valid;
      logic        wen;
      logic        byte_not_word;
      logic        yumi;
   } mem_in_s;

   // Response to the core.
   // yumi here is the memory's single-cycle request accept strobe.
   typedef struct packed {
      logic [31:0] read_data;
      logic        valid;
      logic        yumi;
   } mem_out_s;

   // Handshake states, prefixed so they never clash with the core's state_e.
   typedef enum logic [1:0] {
      DM_IDLE,
      DM_WAIT,
      DM_RESP
   } dmem_state_e;

   // Width of the latency countdown; holds latency values up to 15.
   localparam int unsigned dmem_cnt_width_lp = 4;

   // Byte-lane write enables for a store.
   // Word stores touch every lane; byte stores touch only the addressed one.
   function automatic logic [3:0] dmem_lane_mask(input logic [1:0] lane,
                                                 input logic       byte_not_word);
      logic [3:0] mask;
      mask = 4'hF;
      if (byte_not_word) begin
         mask = 4'b0001 << lane;
      end
      return mask;
   endfunction

   // Shapes a raw array word into load data.
   // Byte loads pick the little-endian lane and zero-extend it.
   function automatic logic [31:0] dmem_format_load(input logic [31:0] word,
                                                    input logic [1:0]  lane,
                                                    input logic        byte_not_word);
      logic [7:0] sel_byte;
      case (lane)
         2'd0:    sel_byte = word[7:0];
         2'd1:    sel_byte = word[15:8];
         2'd2:    sel_byte = word[23:16];
         default: sel_byte = word[31:24];
      endcase
      return byte_not_word ? {24'b0, sel_byte} : word;
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word-organised storage for the data memory.
// Writes land on the clock edge through per-byte lane enables, so a byte
// store leaves its neighbouring lanes untouched. The read port is purely
// combinational; the caller registers whatever it needs. Contents are never
// reset, which keeps the array mappable onto plain RAM.
module data_mem_array #(
   parameter int addr_width_p = 10
) (
   input  logic                    clk,
   input  logic [3:0]              we_i,
   input  logic [addr_width_p-1:0] waddr_i,
   input  logic [31:0]             wdata_i,
   input  logic [addr_width_p-1:0] raddr_i,
   output logic [31:0]             rdata_o
);

   localparam int depth_lp = 2 ** addr_width_p;

   logic [31:0] mem_q [depth_lp];

   // Commit each enabled byte lane of the write word on the clock edge.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++) begin
         if (we_i[b]) begin
            mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/data_mem.sv
// Single-port data memory behind the core's load/store path.
// One transaction is in flight at a time. A request is accepted in IDLE with
// a combinational yumi pulse. Stores commit to the array on that same edge.
// After a fixed latency the response is presented in RESP until the core
// acknowledges it. The response read_data is registered and holds steady
// while the core stalls.
module data_mem
   import data_mem_pkg::*;
#(
   parameter int addr_width_p = 10,
   parameter int latency_p    = 2
) (
   input  logic     clk,
   input  logic     reset,
   input  mem_in_s  to_mem_i,
   input  logic [31:0] addr_i,
   output mem_out_s from_mem_o
);

   localparam logic [dmem_cnt_width_lp-1:0] lat_m1_lp = dmem_cnt_width_lp'(latency_p - 1);
   localparam logic                         one_cycle_lp = (latency_p == 1);

   // Handshake state and latency countdown.
   dmem_state_e                   state_q, state_d;
   logic [dmem_cnt_width_lp-1:0]  cnt_q, cnt_d;

   // Captured request, valid from the accept edge until the response is acked.
   logic [addr_width_p-1:0]       word_q, word_d;
   logic [1:0]                    lane_q, lane_d;
   logic                          wen_q, wen_d;
   logic                          bnw_q, bnw_d;
   logic [31:0]                   wdata_q, wdata_d;

   // Registered response data.
   logic [31:0]                   read_data_q, read_data_d;

   // Request decode and array hookup.
   logic                          accept;
   logic [addr_width_p-1:0]       req_word;
   logic [1:0]                    req_lane;
   logic [addr_width_p-1:0]       rd_word;
   logic [31:0]                   rd_raw;
   logic [3:0]                    arr_we;
   logic [31:0]                   arr_wdata;

   // The bits above the word index are deliberately ignored so addresses
   // wrap, and write data is held only so the in-flight store stays
   // visible. Folding them here keeps that intent explicit.
   logic                          unused_bits;
   assign unused_bits = ^{addr_i[31:addr_width_p+2], wdata_q};

   assign req_word = addr_i[addr_width_p+1:2];
   assign req_lane = addr_i[1:0];

   // A request is accepted only in IDLE. Reset blocks the strobe so no
   // store can slip into the array while reset is asserted.
   assign accept = (state_q == DM_IDLE) && to_mem_i.valid && !reset;

   // In IDLE the read port looks at the live address, which a
   // single-cycle-latency load needs. Afterwards it tracks the captured word.
   assign rd_word = (state_q == DM_IDLE) ? req_word : word_q;

   // Stores write straight through on the accept edge. Byte stores
   // replicate the byte so whichever lane is enabled sees the right value.
   assign arr_we    = (accept && to_mem_i.wen) ?
                      dmem_lane_mask(req_lane, to_mem_i.byte_not_word) : 4'b0000;
   assign arr_wdata = to_mem_i.byte_not_word ? {4{to_mem_i.write_data[7:0]}} :
                      to_mem_i.write_data;

   data_mem_array #(
      .addr_width_p(addr_width_p)
   ) u_array (
      .clk     (clk),
      .we_i    (arr_we),
      .waddr_i (req_word),
      .wdata_i (arr_wdata),
      .raddr_i (rd_word),
      .rdata_o (rd_raw)
   );

   // Next-state logic: accept and capture, count down the latency, then
   // hold the response until the core acknowledges it.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      word_d      = word_q;
      lane_d      = lane_q;
      wen_d       = wen_q;
      bnw_d       = bnw_q;
      wdata_d     = wdata_q;
      read_data_d = read_data_q;

      case (state_q)
         DM_IDLE: begin
            if (accept) begin
               word_d  = req_word;
               lane_d  = req_lane;
               wen_d   = to_mem_i.wen;
               bnw_d   = to_mem_i.byte_not_word;
               wdata_d = to_mem_i.write_data;
               if (one_cycle_lp) begin
                  state_d     = DM_RESP;
                  cnt_d       = '0;
                  read_data_d = to_mem_i.wen ? 32'b0 :
                                dmem_format_load(rd_raw, req_lane, to_mem_i.byte_not_word);
               end else begin
                  state_d = DM_WAIT;
                  cnt_d   = lat_m1_lp;
               end
            end
         end

         DM_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == dmem_cnt_width_lp'(1)) begin
               state_d     = DM_RESP;
               cnt_d       = '0;
               read_data_d = wen_q ? 32'b0 : dmem_format_load(rd_raw, lane_q, bnw_q);
            end
         end

         DM_RESP: begin
            if (to_mem_i.yumi) begin
               state_d     = DM_IDLE;
               read_data_d = 32'b0;
            end
         end

         default: begin
            state_d = DM_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // State and capture registers. Reset aborts any transaction in flight
   // but leaves the array alone.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= DM_IDLE;
         cnt_q       <= '0;
         word_q      <= '0;
         lane_q      <= '0;
         wen_q       <= 1'b0;
         bnw_q       <= 1'b0;
         wdata_q     <= '0;
         read_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         word_q      <= word_d;
         lane_q      <= lane_d;
         wen_q       <= wen_d;
         bnw_q       <= bnw_d;
         wdata_q     <= wdata_d;
         read_data_q <= read_data_d;
      end
   end

   assign from_mem_o.read_data = read_data_q;
   assign from_mem_o.valid     = (state_q == DM_RESP);
   assign from_mem_o.yumi      = accept;

endmodule
